// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory-access stage.
package mem_stage_pkg;

    localparam int ARQ_DEF    = 16;
    localparam int ADDR_W_DEF = 13;
    localparam int RD_W_DEF   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Write-back bundle at the default datapath widths.
    typedef struct packed {
        logic                  valid;
        logic [RD_W_DEF-1:0]   rd;
        logic [ARQ_DEF-1:0]    data;
    } wb_t;

    // Counter width able to hold TIMEOUT; at least one bit even when disabled.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 2);
    endfunction

endpackage

// File: rtl/mem_stage_timeout_counter.sv
// Wait-cycle counter: cleared while idle, counts while waiting, flags the last
// permitted cycle. A zero limit never expires.
module mem_timeout_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (limit_i != '0) && (count_q == limit_i - CNT_W'(1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs one data-memory access
// at a time over req/ack, and presents a registered one-cycle write-back pulse.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ARQ     = ARQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [ARQ-1:0]    alu_result,
    input  logic [ARQ-1:0]    store_data,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ARQ-1:0]    mem_wdata,
    input  logic [ARQ-1:0]    mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [ARQ-1:0]    wb_data,
    output logic              fault
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    // Same layout as the package bundle, sized by this instance's parameters.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic [ARQ-1:0]  data;
    } wb_bundle_t;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ARQ-1:0]    wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              load_wb_q, load_wb_d;
    logic              fault_q, fault_d;
    wb_bundle_t        wb_q, wb_d;

    logic accept;
    logic addr_hi_nz;
    logic expire;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready && !flush;
    assign addr_hi_nz = |alu_result[ARQ-1:ADDR_W];

    mem_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == IDLE),
        .en_i     (state_q == WAIT),
        .limit_i  (CNT_W'(TIMEOUT)),
        .expire_o (expire)
    );

    // Next-state: accept in IDLE, complete or abort the access in WAIT.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        load_wb_d = load_wb_q;
        fault_d   = fault_q;
        wb_d      = wb_q;
        wb_d.valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!mem_read && !mem_write) begin
                        if (reg_write) begin
                            wb_d.valid = 1'b1;
                            wb_d.rd    = rd_addr;
                            wb_d.data  = alu_result;
                        end
                    end else if ((mem_read && mem_write) || addr_hi_nz) begin
                        // Malformed access: swallow it and flag the error.
                        fault_d = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        req_d     = 1'b1;
                        we_d      = mem_write;
                        addr_d    = alu_result[ADDR_W-1:0];
                        wdata_d   = store_data;
                        rd_d      = rd_addr;
                        load_wb_d = mem_read && reg_write;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (load_wb_q) begin
                        wb_d.valid = 1'b1;
                        wb_d.rd    = rd_q;
                        wb_d.data  = mem_rdata;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            load_wb_q <= 1'b0;
            fault_q   <= 1'b0;
            wb_q      <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            load_wb_q <= load_wb_d;
            fault_q   <= fault_d;
            wb_q      <= wb_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_q.valid;
    assign wb_rd     = wb_q.rd;
    assign wb_data   = wb_q.data;
    assign fault     = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout so the abort path is reachable.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [3:0]  rd_addr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        fault;

    int total;
    int bad;

    mem_stage #(
        .ARQ     (16),
        .ADDR_W  (13),
        .RD_W    (4),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd_addr    (rd_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid   = 1'b0;
        flush      = 1'b0;
        alu_result = '0;
        store_data = '0;
        rd_addr    = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic rw,
                         input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] rd);
        in_valid   = 1'b1;
        flush      = 1'b0;
        mem_read   = rd_en;
        mem_write  = wr_en;
        reg_write  = rw;
        alu_result = alu;
        store_data = sd;
        rd_addr    = rd;
    endtask

    initial begin
        int req_cycles;
        int wb_seen;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        idle_in();

        // Reset state
        step();
        step();
        chk("rst_req", mem_req, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b1;
        step();

        // ALU pass-through
        issue(0, 0, 1, 16'h1234, 16'h0, 4'd3);
        step();
        chk("alu_wbv", wb_valid, 1);
        chk("alu_rd", wb_rd, 3);
        chk("alu_data", wb_data, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 1, 16'h1111 + 16'(i), 16'h0, 4'(6 + i));
            step();
            chk("b2b_wbv", wb_valid, 1);
            chk("b2b_rd", wb_rd, 32'(6 + i));
            chk("b2b_data", wb_data, 32'(16'h1111 + i));
            chk("b2b_ready", in_ready, 1);
        end
        idle_in();
        step();
        chk("alu_pulse_end", wb_valid, 0);

        // ALU op without reg_write
        issue(0, 0, 0, 16'h7777, 16'h0, 4'd1);
        step();
        idle_in();
        chk("alu_norw_wbv", wb_valid, 0);

        // Load, ack in third WAIT cycle
        issue(1, 0, 1, 16'h0040, 16'h0, 4'd5);
        step();
        idle_in();
        chk("ld_req1", mem_req, 1);
        chk("ld_addr", mem_addr, 13'h0040);
        chk("ld_we", mem_we, 0);
        chk("ld_ready1", in_ready, 0);
        chk("ld_wbv1", wb_valid, 0);
        // flush during WAIT must not disturb the access
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        idle_in();
        chk("ld_req2", mem_req, 1);
        chk("ld_ready2", in_ready, 0);
        step();
        chk("ld_req3", mem_req, 1);
        chk("ld_ready3", in_ready, 0);
        chk("ld_addr3", mem_addr, 13'h0040);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_wbv", wb_valid, 1);
        chk("ld_rd", wb_rd, 5);
        chk("ld_data", wb_data, 16'hBEEF);
        chk("ld_ready", in_ready, 1);
        step();
        chk("ld_pulse_end", wb_valid, 0);

        // Store, ack after one cycle
        issue(0, 1, 0, 16'h0100, 16'hA5A5, 4'd9);
        step();
        idle_in();
        chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 13'h0100);
        chk("st_wdata", mem_wdata, 16'hA5A5);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_req_drop", mem_req, 0);
        chk("st_wbv", wb_valid, 0);
        chk("st_ready", in_ready, 1);
        chk("st_fault", fault, 0);

        // Flush: no effect for ALU or memory op
        issue(0, 0, 1, 16'h4444, 16'h0, 4'd4);
        flush = 1'b1;
        step();
        chk("flush_alu_wbv", wb_valid, 0);
        issue(1, 0, 1, 16'h0010, 16'h0, 4'd4);
        flush = 1'b1;
        step();
        idle_in();
        chk("flush_ld_req", mem_req, 0);
        chk("flush_ld_ready", in_ready, 1);

        // Late ack in IDLE ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ack   = 1'b0;
        chk("idle_ack_wbv", wb_valid, 0);
        chk("idle_ack_req", mem_req, 0);

        // Address fault: upper bits set
        issue(1, 0, 1, 16'hE000, 16'h0, 4'd2);
        step();
        idle_in();
        chk("af_req", mem_req, 0);
        chk("af_fault", fault, 1);
        chk("af_wbv", wb_valid, 0);
        chk("af_ready", in_ready, 1);
        step();
        chk("af_req2", mem_req, 0);
        chk("af_wbv2", wb_valid, 0);

        // Reset clears fault; then read+write both set faults
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("clr_fault", fault, 0);
        issue(1, 1, 1, 16'h0020, 16'h0, 4'd2);
        step();
        idle_in();
        chk("rw_req", mem_req, 0);
        chk("rw_fault", fault, 1);
        chk("rw_wbv", wb_valid, 0);

        // Timeout with TIMEOUT = 4
        rst = 1'b0;
        step();
        rst = 1'b1;
        issue(1, 0, 1, 16'h0002, 16'h0, 4'd7);
        step();
        idle_in();
        req_cycles = 0;
        wb_seen    = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) req_cycles++;
            if (wb_valid) wb_seen++;
            step();
        end
        chk("to_req_cycles", req_cycles, 4);
        chk("to_wb_seen", wb_seen, 0);
        chk("to_fault", fault, 1);
        chk("to_ready", in_ready, 1);
        issue(0, 0, 1, 16'h0055, 16'h0, 4'd2);
        step();
        idle_in();
        chk("to_alu_wbv", wb_valid, 1);
        chk("to_alu_data", wb_data, 16'h0055);
        chk("to_fault_sticky", fault, 1);

        // Reset mid-WAIT
        rst = 1'b0;
        step();
        rst = 1'b1;
        issue(1, 0, 1, 16'h0033, 16'h0, 4'd8);
        step();
        idle_in();
        step();
        chk("mr_req_pre", mem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_req", mem_req, 0);
        chk("mr_addr", mem_addr, 0);
        chk("mr_wbv", wb_valid, 0);
        chk("mr_wbdata", wb_data, 0);
        chk("mr_ready", in_ready, 1);
        step();
        rst = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hCAFE;
        step();
        mem_ack = 1'b0;
        chk("mr_ack_wbv", wb_valid, 0);
        chk("mr_ack_req", mem_req, 0);
        step();
        chk("mr_ack_wbv2", wb_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage: consumes the ALU result, store data and control bits.
- Performs data-memory loads/stores over a req/ack handshake and back-pressures execute while an access is outstanding.
- Presents a registered write-back bundle to the register file.
- ALU-only instructions pass through with one cycle of latency.

Parameters:
- ARQ, 16, datapath width (matches execute stage)
- ADDR_W, 13, data-memory word-address width
- RD_W, 4, destination register index width
- TIMEOUT, 64, max cycles waiting for mem_ack before abort; 0 disables the timeout

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  kill the instruction presented this cycle (branch redirect)
- alu_result  in  ARQ  ALU output; data for ALU ops, address for memory ops
- store_data  in  ARQ  data to store
- rd_addr  in  RD_W  destination register
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- reg_write  in  1  instruction writes a register
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  ARQ  store data
- mem_rdata  in  ARQ  load data, valid when mem_ack = 1
- mem_ack  in  1  memory completes the access this cycle
- wb_valid  out  1  one-cycle write-back strobe
- wb_rd  out  RD_W  write-back register
- wb_data  out  ARQ  write-back data
- fault  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - mem_req, mem_we, wb_valid and fault are 0.
  - mem_addr, mem_wdata, wb_rd and wb_data are 0.
  - The timeout counter is 0.
  - Reset during WAIT abandons the access; no write-back follows.
- States: IDLE and WAIT. in_ready = (state == IDLE), combinational.
- Accept condition: in_valid & in_ready & ~flush. A flushed or non-accepted cycle produces no effect and wb_valid = 0 next cycle.
- Accepted ALU op (mem_read = mem_write = 0):
  - wb_valid = reg_write next cycle, with wb_rd = rd_addr and wb_data = alu_result.
  - Back-to-back ALU ops are accepted every cycle.
- Accepted memory op (exactly one of mem_read/mem_write set, and alu_result[ARQ-1:ADDR_W] == 0):
  - Next cycle: state = WAIT, mem_req = 1, mem_we = mem_write, mem_addr = alu_result[ADDR_W-1:0], mem_wdata = store_data, counter = 0.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until ack or abort.
- In WAIT, mem_ack = 1 sampled at an edge:
  - mem_req drops and state returns to IDLE.
  - For a load with reg_write set: wb_valid = 1 next cycle, wb_data = mem_rdata captured at that edge, wb_rd = the latched rd_addr.
  - For a store: no write-back.
  - Minimum load latency is 2 cycles, accept edge to wb_valid.
- In WAIT without ack:
  - The counter increments each cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ack: mem_req drops, fault sets, state returns to IDLE, no write-back.
  - A late mem_ack arriving in IDLE is ignored.
- Address fault: a memory op with nonzero upper address bits, or with mem_read & mem_write both set, is accepted but:
  - no request is issued and no write-back occurs;
  - fault sets; state stays IDLE.
- flush during WAIT is ignored; the outstanding access completes normally.
- wb_valid is a single-cycle pulse per instruction; it is never asserted while rst = 0.
- mem_ack is ignored in IDLE.

Decomposition:
- Shared package holds:
  - state enum {IDLE, WAIT};
  - a write-back bundle struct {valid, rd, data};
  - default widths ARQ = 16, ADDR_W = 13, RD_W = 4.
- One natural sub-module: mem_timeout_counter (clear/enable/limit inputs, expire output).

Test Plan:
- ALU pass-through: accept alu_result = 0x1234, rd = 3, reg_write = 1 -> next cycle wb_valid = 1, wb_rd = 3, wb_data = 0x1234; three consecutive ops give three consecutive pulses.
- Load with ack on the 3rd WAIT cycle: alu_result = 0x0040, rdata = 0xBEEF, rd = 5 -> mem_req high 3 cycles, mem_addr = 0x0040, in_ready = 0 throughout, then wb_data = 0xBEEF, wb_rd = 5, single pulse.
- Store: alu_result = 0x0100, store_data = 0xA5A5, ack after 1 cycle -> mem_we = 1, mem_wdata = 0xA5A5, no wb_valid, in_ready = 1 the cycle after ack.
- Timeout with TIMEOUT = 4 and no ack -> mem_req high exactly 4 cycles, fault = 1, no write-back; a later ALU op still writes back normally; fault stays 1.
- Address fault: load with alu_result = 0xE000 -> mem_req stays 0, fault = 1, no wb_valid. Flush: in_valid = 1, flush = 1 -> no effect.
- Reset mid-WAIT: assert rst = 0 asynchronously in cycle 2 of a load -> all outputs 0 immediately; a subsequent mem_ack is ignored; no write-back.
